line_fill_responder: RTL and testbench
======================================

LINE_FILL_RESPONDER -- requirements
Module: line_fill_responder

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset, on the following ports:
- clk  in  1  single clock.
- reset  in  1  synchronous reset, active-high.
REQ-002 SHALL have the following ports:
- is_req_f_prog  in  1  prog cache line-fill request; held high until the line completes.
- req_addr_f_prog  in  20  prog line address.
- is_req_f_data  in  1  data cache line-fill request; held high until the line completes.
- req_addr_f_data  in  20  data line address.
- mem_re  out  1  backing-memory read strobe.
- mem_addr  out  26  backing-memory beat address, {line addr[19:0], beat[5:0]}.
- mem_rdata  in  512  read data; valid exactly 1 cycle after mem_re.
- read_prog_data  out  512  beat data to the prog cache.
- read_prog_addr  out  8  {req_addr_f_prog[1:0], beat[5:0]}.
- is_write_prog_line  out  1  beat valid strobe, prog channel.
- read_data_data, read_data_addr, is_write_data_line  out  512/8/1  same three signals for the data channel.
- busy  out  1  high in any state other than IDLE.

Function
REQ-003 SHALL implement the states IDLE, BURST, LAST and WAIT_DROP.
REQ-004 Arbitration SHALL be sampled only in IDLE:
- Single request: that channel is granted.
- Both requesting: the channel not served last is granted; prog wins after reset.
REQ-005 On grant, the responder SHALL latch the channel's 20-bit address, clear beat to 0 and enter BURST the next cycle.
REQ-006 BURST SHALL behave as follows:
- Every cycle: mem_re=1, mem_addr={latched addr, beat}, beat increments.
- After issuing beat 63: go to LAST.
REQ-007 The beat issued in cycle N SHALL be presented in cycle N+1 on the granted channel only:
- data = mem_rdata.
- addr = {latched addr[1:0], issued beat}.
- is_write_*_line=1.
REQ-008 In LAST, mem_re SHALL be 0, beat 63 SHALL be presented per REQ-007, and the state SHALL then go to WAIT_DROP.
REQ-009 Burst timing SHALL be:
- First write strobe 2 cycles after the request is sampled in IDLE.
- 64 strobes on 64 consecutive cycles with no gaps.
- Strobed addresses increase 0..63 in the low 6 bits.
REQ-010 WAIT_DROP SHALL hold all strobes low and return to IDLE in the cycle after the served request is seen low.
REQ-011 A new grant SHALL occur no earlier than the IDLE cycle; a request that is still high in WAIT_DROP SHALL NOT restart a burst.
REQ-012 The non-granted channel SHALL see is_write low for the whole transaction; its read_*_data/addr SHALL hold their previous values.
REQ-013 If the served request drops during BURST, the responder SHALL abort:
- mem_re=0 from the next cycle.
- The strobe for the in-flight beat is suppressed.
- Return to IDLE; no further strobes for that transaction.
REQ-014 Changes to req_addr_* after grant SHALL be ignored until the next grant.
REQ-015 Beat counter arithmetic SHALL be 6-bit; beat 63 SHALL be detected explicitly and the counter SHALL never wrap into beat 0 within one burst.
REQ-016 mem_addr SHALL hold its last value when mem_re=0.

Reset
REQ-017 While reset=1 at a clk edge, the responder SHALL enter IDLE and clear:
- Outputs: mem_re, mem_addr, all read_*_data, read_*_addr, is_write_*_line, busy.
- Internal state: beat, latched address, round-robin pointer (prog priority).
REQ-018 Reset asserted mid-burst SHALL abort the burst immediately: no strobe in the cycle after the reset edge, and no pending beat is emitted after release.
REQ-019 After reset release, a request held high SHALL be granted in the first IDLE sample.

Verification
REQ-020 Single prog fill:
- Stimulus: prog req, addr 20'h00003; memory model returns beat index in mem_rdata[5:0].
- Response: 64 prog strobes, read_prog_addr 8'hC0..8'hFF, data low bits 0..63, mem_addr 26'h000C0..26'h000FF, no data strobes.
REQ-021 Simultaneous requests after reset:
- Stimulus: prog and data asserted in the same cycle.
- Response: prog served first; data granted in the IDLE cycle after prog drops; 64 data strobes follow.
REQ-022 Back-to-back fairness:
- Stimulus: both requests re-asserted continuously.
- Response: grants alternate prog, data, prog.
REQ-023 Abort:
- Stimulus: drop data req after its 10th strobe.
- Response: at most 10 strobes total; busy low within 2 cycles; next request served normally from beat 0.
REQ-024 Reset mid-burst:
- Stimulus: assert reset at beat 30 for 1 cycle.
- Response: all outputs 0 the cycle after; with req still high, a fresh burst starts at beat 0 two cycles after release.
REQ-025 Hold after completion:
- Stimulus: keep prog req high for 5 cycles after beat 63.
- Response: no extra strobes and busy=1 until drop; IDLE one cycle after drop.

Source files
------------

// File: rtl/line_fill_responder.sv
// rtl/line_fill_responder.sv - two-channel cache line-fill responder, 64-beat bursts
// Round-robin between prog and data fill requests; each grant streams one line from backing memory.
module line_fill_responder (
  input  logic         clk,
  input  logic         reset,
  input  logic         is_req_f_prog,
  input  logic [19:0]  req_addr_f_prog,
  input  logic         is_req_f_data,
  input  logic [19:0]  req_addr_f_data,
  output logic         mem_re,
  output logic [25:0]  mem_addr,
  input  logic [511:0] mem_rdata,
  output logic [511:0] read_prog_data,
  output logic [7:0]   read_prog_addr,
  output logic         is_write_prog_line,
  output logic [511:0] read_data_data,
  output logic [7:0]   read_data_addr,
  output logic         is_write_data_line,
  output logic         busy
);

  localparam logic [1:0] S_IDLE      = 2'd0;
  localparam logic [1:0] S_BURST     = 2'd1;
  localparam logic [1:0] S_LAST      = 2'd2;
  localparam logic [1:0] S_WAIT_DROP = 2'd3;

  logic [1:0]   state_q, state_d;
  logic         chan_q, chan_d;      // 0 = prog, 1 = data
  logic         prio_q, prio_d;      // 1 = data preferred on contention
  logic [5:0]   beat_q, beat_d;
  logic [19:0]  addr_q, addr_d;
  logic [25:0]  mem_addr_q, mem_addr_d;
  logic         pend_q, pend_d;
  logic [511:0] read_prog_data_q, read_prog_data_d;
  logic [511:0] read_data_data_q, read_data_data_d;
  logic [7:0]   read_prog_addr_q, read_prog_addr_d;
  logic [7:0]   read_data_addr_q, read_data_addr_d;

  logic served_req;
  logic issue;
  logic grant_any;
  logic grant_sel;

  assign served_req = chan_q ? is_req_f_data : is_req_f_prog;
  assign issue      = (state_q == S_BURST);
  assign grant_any  = is_req_f_prog | is_req_f_data;
  assign grant_sel  = is_req_f_data & (~is_req_f_prog | prio_q);

  always_comb begin
    state_d          = state_q;
    chan_d           = chan_q;
    prio_d           = prio_q;
    beat_d           = beat_q;
    addr_d           = addr_q;
    mem_addr_d       = mem_addr_q;
    pend_d           = 1'b0;
    read_prog_data_d = read_prog_data_q;
    read_data_data_d = read_data_data_q;
    read_prog_addr_d = read_prog_addr_q;
    read_data_addr_d = read_data_addr_q;

    // Beat data arrives one cycle after issue; capture it so the outputs hold afterwards.
    if (pend_q && !chan_q) read_prog_data_d = mem_rdata;
    if (pend_q && chan_q)  read_data_data_d = mem_rdata;

    case (state_q)
      S_IDLE: begin
        if (grant_any) begin
          state_d = S_BURST;
          chan_d  = grant_sel;
          prio_d  = ~grant_sel;
          addr_d  = grant_sel ? req_addr_f_data : req_addr_f_prog;
          beat_d  = 6'd0;
        end
      end
      S_BURST: begin
        mem_addr_d = {addr_q, beat_q};
        // A dropped request kills the beat issued this cycle as well.
        pend_d     = served_req;
        if (served_req) begin
          if (chan_q) read_data_addr_d = {addr_q[1:0], beat_q};
          else        read_prog_addr_d = {addr_q[1:0], beat_q};
        end
        if (!served_req) begin
          state_d = S_IDLE;
        end else if (beat_q == 6'd63) begin
          state_d = S_LAST;
        end else begin
          beat_d = beat_q + 6'd1;
        end
      end
      S_LAST: begin
        state_d = S_WAIT_DROP;
      end
      S_WAIT_DROP: begin
        if (!served_req) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q          <= S_IDLE;
      chan_q           <= 1'b0;
      prio_q           <= 1'b0;
      beat_q           <= 6'd0;
      addr_q           <= 20'd0;
      mem_addr_q       <= 26'd0;
      pend_q           <= 1'b0;
      read_prog_data_q <= '0;
      read_data_data_q <= '0;
      read_prog_addr_q <= 8'd0;
      read_data_addr_q <= 8'd0;
    end else begin
      state_q          <= state_d;
      chan_q           <= chan_d;
      prio_q           <= prio_d;
      beat_q           <= beat_d;
      addr_q           <= addr_d;
      mem_addr_q       <= mem_addr_d;
      pend_q           <= pend_d;
      read_prog_data_q <= read_prog_data_d;
      read_data_data_q <= read_data_data_d;
      read_prog_addr_q <= read_prog_addr_d;
      read_data_addr_q <= read_data_addr_d;
    end
  end

  assign mem_re             = issue;
  assign mem_addr           = issue ? {addr_q, beat_q} : mem_addr_q;
  assign is_write_prog_line = pend_q & ~chan_q;
  assign is_write_data_line = pend_q & chan_q;
  assign read_prog_data     = is_write_prog_line ? mem_rdata : read_prog_data_q;
  assign read_data_data     = is_write_data_line ? mem_rdata : read_data_data_q;
  assign read_prog_addr     = read_prog_addr_q;
  assign read_data_addr     = read_data_addr_q;
  assign busy               = (state_q != S_IDLE);

endmodule

// File: tb/tb_line_fill_responder.sv
// tb/tb_line_fill_responder.sv - scoreboard bench for line_fill_responder
// Stimulus pushes expected strobes (channel, addr, data, cycle); a negedge monitor pops and compares.
module tb_line_fill_responder;

  logic         clk = 1'b0;
  logic         reset;
  logic         is_req_f_prog;
  logic [19:0]  req_addr_f_prog;
  logic         is_req_f_data;
  logic [19:0]  req_addr_f_data;
  logic         mem_re;
  logic [25:0]  mem_addr;
  logic [511:0] mem_rdata = '0;
  logic [511:0] read_prog_data;
  logic [7:0]   read_prog_addr;
  logic         is_write_prog_line;
  logic [511:0] read_data_data;
  logic [7:0]   read_data_addr;
  logic         is_write_data_line;
  logic         busy;

  always #5 clk = ~clk;

  line_fill_responder dut (
    .clk                (clk),
    .reset              (reset),
    .is_req_f_prog      (is_req_f_prog),
    .req_addr_f_prog    (req_addr_f_prog),
    .is_req_f_data      (is_req_f_data),
    .req_addr_f_data    (req_addr_f_data),
    .mem_re             (mem_re),
    .mem_addr           (mem_addr),
    .mem_rdata          (mem_rdata),
    .read_prog_data     (read_prog_data),
    .read_prog_addr     (read_prog_addr),
    .is_write_prog_line (is_write_prog_line),
    .read_data_data     (read_data_data),
    .read_data_addr     (read_data_addr),
    .is_write_data_line (is_write_data_line),
    .busy               (busy)
  );

  // Memory returns the beat address it was asked for, one cycle later.
  always @(posedge clk) mem_rdata <= mem_re ? {486'd0, mem_addr} : '0;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic        ch;
    logic [7:0]  addr;
    logic [25:0] dlo;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   vec  = 0;
  int   miss = 0;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    vec++;
    if (act !== exp) begin
      miss++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  task automatic push_burst(input logic ch, input logic [19:0] a, input int g, input int nbeats);
    for (int i = 0; i < nbeats; i++) begin
      exp_t e;
      e.ch   = ch;
      e.addr = {a[1:0], 6'(i)};
      e.dlo  = {a, 6'(i)};
      e.cyc  = g + 2 + i;
      sb.push_back(e);
    end
  endtask

  task automatic wait_to(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (is_write_prog_line || is_write_data_line) begin
      if (sb.size() == 0) begin
        vec++;
        miss++;
        $display("FAIL unexpected_strobe: got prog=%0b data=%0b expected none (cycle %0d)",
                 is_write_prog_line, is_write_data_line, cyc);
      end else begin
        mon_e = sb.pop_front();
        chk("strobe_chan", {is_write_data_line, is_write_prog_line}, mon_e.ch ? 2'b10 : 2'b01);
        chk("strobe_cycle", cyc, mon_e.cyc);
        chk("strobe_addr", mon_e.ch ? read_data_addr : read_prog_addr, mon_e.addr);
        chk("strobe_data", mon_e.ch ? read_data_data[25:0] : read_prog_data[25:0], mon_e.dlo);
      end
    end
  end

  int n;

  initial begin
    reset           = 1'b1;
    is_req_f_prog   = 1'b0;
    is_req_f_data   = 1'b0;
    req_addr_f_prog = 20'd0;
    req_addr_f_data = 20'd0;
    repeat (2) @(negedge clk);
    chk("rst_mem_re", mem_re, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_busy", busy, 0);
    chk("rst_strobes", {is_write_prog_line, is_write_data_line}, 0);
    chk("rst_prog_addr", read_prog_addr, 0);
    chk("rst_prog_data", read_prog_data[63:0], 0);
    reset = 1'b0;

    // Single prog fill, address change after grant, hold 5 cycles after beat 63.
    @(negedge clk);
    n = cyc;
    is_req_f_prog   = 1'b1;
    req_addr_f_prog = 20'h00003;
    push_burst(1'b0, 20'h00003, n, 64);
    wait_to(n + 5);
    req_addr_f_prog = 20'hABCDE;
    wait_to(n + 30);
    chk("burst_busy", busy, 1);
    chk("burst_mem_re", mem_re, 1);
    chk("burst_mem_addr", mem_addr, {20'h00003, 6'd29});
    wait_to(n + 71);
    chk("hold_busy", busy, 1);
    chk("hold_mem_re", mem_re, 0);
    is_req_f_prog = 1'b0;
    wait_to(n + 72);
    chk("drop_busy", busy, 0);
    chk("drop_mem_addr_hold", mem_addr, 26'h00000FF);
    chk("prog_addr_hold", read_prog_addr, 8'hFF);
    chk("data_chan_untouched", read_data_addr, 8'h00);

    // Simultaneous requests after reset, then continuous re-assertion.
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    n = cyc;
    is_req_f_prog   = 1'b1;
    is_req_f_data   = 1'b1;
    req_addr_f_prog = 20'h12345;
    req_addr_f_data = 20'h00002;
    push_burst(1'b0, 20'h12345, n, 64);
    push_burst(1'b1, 20'h00002, n + 67, 64);
    push_burst(1'b0, 20'hFFFFF, n + 134, 64);
    wait_to(n + 66);
    is_req_f_prog = 1'b0;
    wait_to(n + 67);
    chk("between_grants_busy", busy, 0);
    is_req_f_prog   = 1'b1;
    req_addr_f_prog = 20'hFFFFF;
    wait_to(n + 133);
    is_req_f_data = 1'b0;
    wait_to(n + 134);
    is_req_f_data = 1'b1;
    wait_to(n + 200);
    is_req_f_prog = 1'b0;
    is_req_f_data = 1'b0;
    wait_to(n + 202);
    chk("rr_end_busy", busy, 0);

    // Abort: data request dropped right after its 10th strobe.
    n = cyc;
    is_req_f_data   = 1'b1;
    req_addr_f_data = 20'h55551;
    push_burst(1'b1, 20'h55551, n, 10);
    wait_to(n + 11);
    is_req_f_data = 1'b0;
    wait_to(n + 12);
    chk("abort_busy", busy, 0);
    chk("abort_mem_re", mem_re, 0);
    chk("abort_data_addr", read_data_addr, 8'h49);
    wait_to(n + 20);
    n = cyc;
    is_req_f_prog   = 1'b1;
    req_addr_f_prog = 20'h00007;
    push_burst(1'b0, 20'h00007, n, 64);
    wait_to(n + 66);
    is_req_f_prog = 1'b0;
    wait_to(n + 67);
    chk("post_abort_busy", busy, 0);

    // Reset during beat 30 with the request held high.
    n = cyc;
    is_req_f_prog   = 1'b1;
    req_addr_f_prog = 20'h0ABC0;
    push_burst(1'b0, 20'h0ABC0, n, 30);
    wait_to(n + 31);
    reset = 1'b1;
    wait_to(n + 32);
    chk("midrst_mem_re", mem_re, 0);
    chk("midrst_mem_addr", mem_addr, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_strobes", {is_write_prog_line, is_write_data_line}, 0);
    chk("midrst_prog_addr", read_prog_addr, 0);
    chk("midrst_prog_data", read_prog_data[63:0], 0);
    chk("midrst_data_addr", read_data_addr, 0);
    chk("midrst_data_data", read_data_data[63:0], 0);
    reset = 1'b0;
    push_burst(1'b0, 20'h0ABC0, n + 32, 64);
    wait_to(n + 98);
    is_req_f_prog = 1'b0;
    wait_to(n + 99);
    chk("post_rst_busy", busy, 0);

    repeat (5) @(negedge clk);
    chk("sb_empty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule
